// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// Start/done handshake; results publish only on the completion edge.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrowOut,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             a_msb;
   logic             b_msb;

   logic             d;
   logic             br_next;
   logic [WIDTH-1:0] res_next;
   logic             accept;

   assign d        = sa[0] ^ sb[0] ^ br;
   assign br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign res_next = {d, res[WIDTH-1:1]};
   assign accept   = start && (state == IDLE || state == DONE);

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sa        <= '0;
         sb        <= '0;
         res       <= '0;
         cnt       <= '0;
         br        <= 1'b0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         diff      <= '0;
         borrowOut <= 1'b0;
         overflow  <= 1'b0;
      end else if (accept) begin
         state <= RUN;
         sa    <= a;
         sb    <= b;
         res   <= '0;
         cnt   <= '0;
         br    <= 1'b0;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else begin
         unique case (state)
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               res <= res_next;
               br  <= br_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // d is the MSB of the finished result
                  diff      <= res_next;
                  borrowOut <= br_next;
                  overflow  <= (a_msb != b_msb) && (d != a_msb);
                  state     <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
